// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES link controller.
// Holds the TX/RX state encodings and the UART-style line levels.
package serdes_pkg;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HUNT,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/serdes_bit_timer.sv
// Bit-period counter: restarts on clear or at the end of a period, and strobes
// when the count reaches a caller-selected position (mid-bit or end-of-bit).
module serdes_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] tick_at,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (count == LAST_CNT)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == tick_at);

endmodule

// File: rtl/serdes_link_ctrl.sv
// Sequencing controller for the SERDES datapath: UART-style TX framing with
// serializer strobes, and a mid-bit sampling RX with deserializer strobes.
module serdes_link_ctrl
  import serdes_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_valid,
  output logic tx_ready,
  output logic data_en,
  output logic ser_en,
  input  logic ser_bit,
  output logic line_out,
  input  logic line_in,
  output logic rx_shift,
  output logic par_en,
  output logic rx_valid,
  input  logic rx_ack,
  output logic frame_err,
  output logic overrun
);

  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  // The first T_IDLE cycle still drives the stop level, so T_STOP is one short.
  localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_t        tx_state, tx_next;
  logic [BIT_W-1:0] tx_bit_cnt;
  logic             tx_clear, tx_tick;
  logic [CNT_W-1:0] tx_tick_at;

  rx_state_t        rx_state, rx_next;
  logic [BIT_W-1:0] rx_bit_cnt;
  logic             rx_clear, rx_tick;
  logic [CNT_W-1:0] rx_tick_at;
  logic [1:0]       line_sync;
  logic             line_s, line_prev;

  serdes_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tx_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tx_clear),
    .tick_at (tx_tick_at),
    .tick    (tx_tick)
  );

  serdes_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_rx_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_clear),
    .tick_at (rx_tick_at),
    .tick    (rx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= T_IDLE;
      tx_bit_cnt <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state != T_DATA) begin
        tx_bit_cnt <= '0;
      end else if (tx_tick) begin
        tx_bit_cnt <= (tx_bit_cnt == LAST_BIT) ? '0 : tx_bit_cnt + BIT_W'(1);
      end
    end
  end

  always_comb begin
    tx_next    = tx_state;
    tx_ready   = 1'b0;
    data_en    = 1'b0;
    ser_en     = 1'b0;
    line_out   = LINE_IDLE;
    tx_clear   = 1'b0;
    tx_tick_at = LAST_CNT;
    case (tx_state)
      T_IDLE: begin
        tx_ready = 1'b1;
        tx_clear = 1'b1;
        if (tx_valid) begin
          data_en = 1'b1;
          tx_next = T_START;
        end
      end
      T_START: begin
        line_out = START_BIT;
        if (tx_tick) tx_next = T_DATA;
      end
      T_DATA: begin
        line_out = ser_bit;
        if (tx_tick) begin
          ser_en = 1'b1;
          if (tx_bit_cnt == LAST_BIT) tx_next = T_STOP;
        end
      end
      T_STOP: begin
        line_out   = STOP_BIT;
        tx_tick_at = STOP_CNT;
        if (tx_tick) begin
          tx_clear = 1'b1;
          tx_next  = T_IDLE;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_sync <= {LINE_IDLE, LINE_IDLE};
      line_prev <= LINE_IDLE;
    end else begin
      line_sync <= {line_sync[0], line_in};
      line_prev <= line_s;
    end
  end

  assign line_s = line_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= R_HUNT;
      rx_bit_cnt <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state != R_DATA) begin
        rx_bit_cnt <= '0;
      end else if (rx_tick) begin
        rx_bit_cnt <= (rx_bit_cnt == LAST_BIT) ? '0 : rx_bit_cnt + BIT_W'(1);
      end
    end
  end

  always_comb begin
    rx_next    = rx_state;
    rx_shift   = 1'b0;
    par_en     = 1'b0;
    frame_err  = 1'b0;
    rx_clear   = 1'b0;
    rx_tick_at = LAST_CNT;
    case (rx_state)
      R_HUNT: begin
        rx_clear = 1'b1;
        if ((line_prev == LINE_IDLE) && (line_s == START_BIT)) rx_next = R_START;
      end
      R_START: begin
        rx_tick_at = MID_CNT;
        if (rx_tick) begin
          rx_clear = 1'b1;
          rx_next  = (line_s == START_BIT) ? R_DATA : R_HUNT;
        end
      end
      R_DATA: begin
        if (rx_tick) begin
          rx_shift = 1'b1;
          if (rx_bit_cnt == LAST_BIT) rx_next = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_tick) begin
          if (line_s == STOP_BIT) par_en = 1'b1;
          else frame_err = 1'b1;
          rx_next = R_HUNT;
        end
      end
      default: rx_next = R_HUNT;
    endcase
  end

  // A word completing in the same cycle as rx_ack replaces the acknowledged one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (par_en) begin
      rx_valid <= 1'b1;
      overrun  <= (overrun | rx_valid) & ~rx_ack;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
